rec_host: RTL and testbench
===========================

REC_HOST -- requirements
Module: rec_host

Interface
REQ-001 Parameter: TIMEOUT, default 1024, maximum RUN cycles before abort (legal 2..2^31).
REQ-002 Parameter: RES_CYCLES, default 2, number of cycles core_res is held high per job (legal 1..15).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 res  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  job request, sampled only in IDLE.
REQ-006 p_a  input  32  initial value for core register A.
REQ-007 p_b  input  32  initial value for core register B.
REQ-008 p_n  input  32  termination value for core register N.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 core_res  output  1  reset to the computation core.
REQ-011 core_din  output  32  parameter word driven to the core's data input.
REQ-012 core_out  input  32  core result (register A).
REQ-013 core_ready  input  1  core completion flag (B equals N).
REQ-014 result  output  32  captured result.
REQ-015 result_valid  output  1  result available; held until acknowledged.
REQ-016 result_ack  input  1  consumer acknowledge.
REQ-017 timeout  output  1  qualifies result: job aborted by the TIMEOUT limit.
REQ-018 cycles  output  32  RUN cycles consumed by the last job.

Function
REQ-019 FSM states SHALL be IDLE, RST, LD_A, LD_B, LD_N, RUN, DONE.
REQ-020 IDLE: start=1 -> latch p_a/p_b/p_n into internal copies, clear cycles and timeout, go to RST.
REQ-021 RST: core_res=1 for exactly RES_CYCLES cycles, then go to LD_A.
REQ-022 LD_A/LD_B/LD_N: one cycle each, core_din = latched p_a/p_b/p_n respectively, core_res=0.
REQ-023 core_din SHALL be 0 in all states other than LD_A/LD_B/LD_N.
REQ-024 core_ready SHALL be ignored in every state except RUN.
REQ-025 RUN: cycles increments by 1 each cycle (saturating at 2^32-1), including the cycle in which core_ready is seen.
REQ-026 RUN with core_ready=1 -> result<=core_out, timeout<=0, go to DONE.
REQ-027 RUN with core_ready=0 and the incremented cycles equal to TIMEOUT -> result<=core_out, timeout<=1, go to DONE.
REQ-028 If core_ready=1 coincides with the TIMEOUT cycle, ready wins (timeout=0).
REQ-029 DONE: result_valid=1; result, timeout and cycles held stable; result_ack=1 -> IDLE next cycle.
REQ-030 result_ack outside DONE SHALL have no effect; start outside IDLE SHALL be ignored (no queueing).
REQ-031 result_valid SHALL drop the cycle after ack; result, timeout and cycles keep their values until the next accepted start.
REQ-032 Latency: start accepted at edge k -> first RUN cycle is edge k+RES_CYCLES+4; ready in the first RUN cycle -> result_valid high at edge k+RES_CYCLES+5, cycles=1.
REQ-033 Changes on p_a/p_b/p_n after start acceptance SHALL NOT affect the running job.

Reset
REQ-034 res=1 at an edge -> state IDLE, result=0, result_valid=0, timeout=0, cycles=0, internal parameter copies=0, busy=0.
REQ-035 core_res SHALL equal res OR (state==RST), so the core is reset together with the host.
REQ-036 res asserted in any state (including mid-load or RUN) aborts the job with no result_valid pulse.
REQ-037 res has priority over start and result_ack in the same cycle.

Verification
REQ-038 RES_CYCLES=2: start with p_a=1, p_b=0, p_n=0 (core_ready high after load) -> core_res high 2 cycles, core_din 1,0,0 in consecutive cycles, result_valid 7 edges after start, cycles=1, timeout=0.
REQ-039 TIMEOUT=8, core_ready held 0 -> DONE after exactly 8 RUN cycles, timeout=1, cycles=8, result=core_out in the final RUN cycle.
REQ-040 core_ready rises on RUN cycle 8 with TIMEOUT=8 -> timeout=0, cycles=8.
REQ-041 result_ack withheld 20 cycles -> result_valid, result, cycles stable all 20 cycles; start pulses during DONE ignored; ack -> IDLE, busy=0 next cycle.
REQ-042 res pulsed during LD_B -> next cycle IDLE, core_res=1 during the res cycle, no result_valid; subsequent start runs normally.
REQ-043 p_a changed from 5 to 9 one cycle after start -> core_din in LD_A equals 5.

Source files
------------

// File: rtl/rec_host.sv
// Job sequencer for a reset/load/run computation core: resets the core, loads A/B/N,
// runs it until ready or a TIMEOUT cycle budget expires, and holds the result until acknowledged.
module rec_host #(
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned RES_CYCLES = 2
) (
    input  logic        clk,
    input  logic        res,
    input  logic        start,
    input  logic [31:0] p_a,
    input  logic [31:0] p_b,
    input  logic [31:0] p_n,
    output logic        busy,
    output logic        core_res,
    output logic [31:0] core_din,
    input  logic [31:0] core_out,
    input  logic        core_ready,
    output logic [31:0] result,
    output logic        result_valid,
    input  logic        result_ack,
    output logic        timeout,
    output logic [31:0] cycles
);

    localparam int unsigned DW  = 32;
    localparam int unsigned RCW = 4;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        LD_A,
        LD_B,
        LD_N,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [RCW-1:0]   rst_cnt;
    logic [DW-1:0]    a_q;
    logic [DW-1:0]    b_q;
    logic [DW-1:0]    n_q;
    logic [DW-1:0]    cycles_inc;
    logic             rst_last;
    logic             limit_hit;

    // Saturating cycle count and end-of-job conditions
    assign cycles_inc = (cycles == '1) ? cycles : cycles + DW'(1);
    assign rst_last   = (rst_cnt == RCW'(RES_CYCLES - 1));
    assign limit_hit  = (cycles_inc == DW'(TIMEOUT));

    // State register
    always_ff @(posedge clk) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RST;
            RST:     if (rst_last) state_nxt = LD_A;
            LD_A:    state_nxt = LD_B;
            LD_B:    state_nxt = LD_N;
            LD_N:    state_nxt = RUN;
            RUN:     if (core_ready || limit_hit) state_nxt = DONE;
            DONE:    if (result_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Parameter copies, reset counter and result registers
    always_ff @(posedge clk) begin
        if (res) begin
            a_q          <= '0;
            b_q          <= '0;
            n_q          <= '0;
            rst_cnt      <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            cycles       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= p_a;
                        b_q     <= p_b;
                        n_q     <= p_n;
                        rst_cnt <= '0;
                        cycles  <= '0;
                        timeout <= 1'b0;
                    end
                end
                RST: begin
                    rst_cnt <= rst_cnt + RCW'(1);
                end
                RUN: begin
                    cycles <= cycles_inc;
                    // Ready wins over a coincident timeout
                    if (core_ready) begin
                        result       <= core_out;
                        timeout      <= 1'b0;
                        result_valid <= 1'b1;
                    end else if (limit_hit) begin
                        result       <= core_out;
                        timeout      <= 1'b1;
                        result_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        result_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Core control decoded from the state register; core reset follows host reset
    assign busy     = (state != IDLE);
    assign core_res = res | (state == RST);

    always_comb begin
        core_din = '0;
        case (state)
            LD_A:    core_din = a_q;
            LD_B:    core_din = b_q;
            LD_N:    core_din = n_q;
            default: core_din = '0;
        endcase
    end

endmodule

// File: tb/tb_rec_host.sv
// Directed self-checking bench for rec_host with RES_CYCLES=2 and TIMEOUT=8.
module tb_rec_host;

    logic        clk;
    logic        res;
    logic        start;
    logic [31:0] p_a;
    logic [31:0] p_b;
    logic [31:0] p_n;
    logic        busy;
    logic        core_res;
    logic [31:0] core_din;
    logic [31:0] core_out;
    logic        core_ready;
    logic [31:0] result;
    logic        result_valid;
    logic        result_ack;
    logic        timeout;
    logic [31:0] cycles;

    int errors = 0;
    int checks = 0;

    rec_host #(.TIMEOUT(8), .RES_CYCLES(2)) dut (
        .clk          (clk),
        .res          (res),
        .start        (start),
        .p_a          (p_a),
        .p_b          (p_b),
        .p_n          (p_n),
        .busy         (busy),
        .core_res     (core_res),
        .core_din     (core_din),
        .core_out     (core_out),
        .core_ready   (core_ready),
        .result       (result),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .timeout      (timeout),
        .cycles       (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        res = 1'b1; start = 1'b0; p_a = '0; p_b = '0; p_n = '0;
        core_out = '0; core_ready = 1'b0; result_ack = 1'b0;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_cycles", cycles, 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_core_res", 32'(core_res), 32'd1);
        chk("rst_core_din", core_din, 32'd0);
        res = 1'b0;
        #1;
        chk("idle_core_res", 32'(core_res), 32'd0);

        // Job 1: ready high throughout, must only be honoured in RUN
        core_ready = 1'b1; core_out = 32'h1234;
        p_a = 32'd1; p_b = 32'd0; p_n = 32'd0; start = 1'b1;
        tick(); start = 1'b0;
        chk("j1_rst1_core_res", 32'(core_res), 32'd1);
        chk("j1_rst1_busy", 32'(busy), 32'd1);
        chk("j1_rst1_din", core_din, 32'd0);
        tick();
        chk("j1_rst2_core_res", 32'(core_res), 32'd1);
        tick();
        chk("j1_lda_core_res", 32'(core_res), 32'd0);
        chk("j1_lda_din", core_din, 32'd1);
        tick();
        chk("j1_ldb_din", core_din, 32'd0);
        chk("j1_ldb_core_res", 32'(core_res), 32'd0);
        tick();
        chk("j1_ldn_din", core_din, 32'd0);
        chk("j1_ldn_valid", 32'(result_valid), 32'd0);
        tick();
        chk("j1_run_valid", 32'(result_valid), 32'd0);
        chk("j1_run_busy", 32'(busy), 32'd1);
        tick();
        chk("j1_done_valid", 32'(result_valid), 32'd1);
        chk("j1_done_result", result, 32'h1234);
        chk("j1_done_cycles", cycles, 32'd1);
        chk("j1_done_timeout", 32'(timeout), 32'd0);

        // Withhold ack for 20 cycles with start pulses and a moving core_out
        for (int i = 0; i < 20; i++) begin
            core_out = 32'hdead0000 + 32'(i);
            start = (i % 2 == 0);
            p_a = 32'(i);
            tick();
            chk("hold_valid", 32'(result_valid), 32'd1);
            chk("hold_result", result, 32'h1234);
            chk("hold_cycles", cycles, 32'd1);
            chk("hold_busy", 32'(busy), 32'd1);
        end
        start = 1'b0;
        result_ack = 1'b1;
        tick(); result_ack = 1'b0;
        chk("ack_valid", 32'(result_valid), 32'd0);
        chk("ack_busy", 32'(busy), 32'd0);
        chk("ack_result_kept", result, 32'h1234);
        chk("ack_cycles_kept", cycles, 32'd1);
        tick();
        chk("no_queued_start", 32'(busy), 32'd0);

        // Job 2: parameter change after start, then timeout after 8 RUN cycles
        core_ready = 1'b0;
        p_a = 32'd5; p_b = 32'd7; p_n = 32'd3; start = 1'b1;
        tick(); start = 1'b0;
        p_a = 32'd9; p_b = 32'd0; p_n = 32'd0;
        chk("j2_cycles_clr", cycles, 32'd0);
        tick();
        tick();
        chk("j2_lda_din", core_din, 32'd5);
        tick();
        chk("j2_ldb_din", core_din, 32'd7);
        tick();
        chk("j2_ldn_din", core_din, 32'd3);
        tick();
        for (int i = 1; i <= 8; i++) begin
            core_out = 32'd100 + 32'(i);
            chk("j2_run_cycles", cycles, 32'(i - 1));
            chk("j2_run_valid", 32'(result_valid), 32'd0);
            chk("j2_run_din", core_din, 32'd0);
            tick();
        end
        chk("j2_to_valid", 32'(result_valid), 32'd1);
        chk("j2_to_timeout", 32'(timeout), 32'd1);
        chk("j2_to_cycles", cycles, 32'd8);
        chk("j2_to_result", result, 32'd108);
        result_ack = 1'b1;
        tick(); result_ack = 1'b0;
        chk("j2_ack_timeout_kept", 32'(timeout), 32'd1);

        // Job 3: ready coincides with the timeout cycle
        start = 1'b1;
        tick(); start = 1'b0;
        chk("j3_timeout_clr", 32'(timeout), 32'd0);
        chk("j3_cycles_clr", cycles, 32'd0);
        tick(); tick(); tick(); tick(); tick();
        for (int i = 1; i <= 8; i++) begin
            core_out = 32'd200 + 32'(i);
            core_ready = (i == 8);
            tick();
        end
        core_ready = 1'b0;
        chk("j3_valid", 32'(result_valid), 32'd1);
        chk("j3_timeout", 32'(timeout), 32'd0);
        chk("j3_cycles", cycles, 32'd8);
        chk("j3_result", result, 32'd208);
        result_ack = 1'b1;
        tick(); result_ack = 1'b0;

        // Job 4: reset during LD_B aborts with no result
        core_ready = 1'b1; core_out = 32'd77; p_a = 32'd4; p_b = 32'd6; p_n = 32'd8;
        start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        chk("j4_ldb_din", core_din, 32'd6);
        res = 1'b1;
        #1;
        chk("j4_res_core_res", 32'(core_res), 32'd1);
        tick(); res = 1'b0;
        #1;
        chk("j4_abort_busy", 32'(busy), 32'd0);
        chk("j4_abort_valid", 32'(result_valid), 32'd0);
        chk("j4_abort_core_res", 32'(core_res), 32'd0);
        chk("j4_abort_result", result, 32'd0);
        chk("j4_abort_cycles", cycles, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("j4_idle_valid", 32'(result_valid), 32'd0);
            chk("j4_idle_busy", 32'(busy), 32'd0);
        end

        // Reset beats a simultaneous start
        res = 1'b1; start = 1'b1;
        tick(); res = 1'b0; start = 1'b0;
        chk("res_over_start", 32'(busy), 32'd0);

        // Job 5: normal job after abort, then reset while in DONE
        core_out = 32'hcafe; p_a = 32'd3; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        chk("j5_run_valid", 32'(result_valid), 32'd0);
        tick();
        chk("j5_valid", 32'(result_valid), 32'd1);
        chk("j5_result", result, 32'hcafe);
        chk("j5_cycles", cycles, 32'd1);
        chk("j5_timeout", 32'(timeout), 32'd0);
        res = 1'b1; result_ack = 1'b1;
        tick(); res = 1'b0; result_ack = 1'b0;
        chk("j5_res_valid", 32'(result_valid), 32'd0);
        chk("j5_res_result", result, 32'd0);
        chk("j5_res_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
